mem_port_arbiter: RTL and testbench

Shares the single synchronous memory port between two requesters: port 0 is the processor (fetch, load, store) and port 1 is a loader/debug DMA master.
- Serialises accesses and drives the memory address, write data and write enable.
- Aligns the memory's fixed read latency and returns read data to the winning requester with a one-cycle valid pulse.
- Sits between the processor/loader and the memory macro.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/rr_arb2.sv | 31 +++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
  localparam int   CNT_W    = 3;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory macro.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Handshake: a requester raises mN_req with we/addr/wdata and holds all four
  // stable until it sees the one-cycle mN_gnt pulse; reads then complete with a
  // one-cycle mN_rvalid pulse, and mN_rdata holds until the next read response.
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-request winner selection with a last-grant register for round-robin.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       fixed_pri,
  input  logic [1:0] req,
  input  logic       take,
  output logic       any_req,
  output logic       winner
);
  logic last_q, last_d;

  always_comb begin
    any_req = |req;
    winner  = PORT_CPU;
    if (req == 2'b10) begin
      winner = PORT_DMA;
    end else if (req == 2'b11) begin
      winner = fixed_pri ? PORT_CPU : ~last_q;
    end
    last_d = take ? winner : last_q;
  end

  // Resetting to the DMA port makes the CPU win the first tie.
  always_ff @(posedge clk) begin
    if (!resetn) last_q <= PORT_DMA;
    else         last_q <= last_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and DMA accesses onto one synchronous memory port and
// returns read data after the memory's fixed latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  mem_port_arbiter_if.slave      bus,
  output state_e                 dbg_state
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             winner_q, winner_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             mem_we_q, mem_we_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata0_q, rdata0_d;
  logic [DW-1:0]    rdata1_q, rdata1_d;
  logic             arb_any, arb_winner, arb_take;

  rr_arb2 u_arb (
    .clk       (clk),
    .resetn    (resetn),
    .fixed_pri (FIXED_PRI != 0),
    .req       ({bus.m1_req, bus.m0_req}),
    .take      (arb_take),
    .any_req   (arb_any),
    .winner    (arb_winner)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    winner_d    = winner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    arb_take    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          arb_take         = 1'b1;
          winner_d         = arb_winner;
          gnt_d[arb_winner] = 1'b1;
          if (arb_winner == PORT_DMA) begin
            mem_addr_d  = bus.m1_addr;
            mem_wdata_d = bus.m1_wdata;
            mem_we_d    = bus.m1_we;
          end else begin
            mem_addr_d  = bus.m0_addr;
            mem_wdata_d = bus.m0_wdata;
            mem_we_d    = bus.m0_we;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The counter expires on the cycle mem_rdata carries this access's data.
        if (cnt_q == '0) begin
          if (winner_q == PORT_DMA) rdata1_d = bus.mem_rdata;
          else                      rdata0_d = bus.mem_rdata;
          rvalid_d[winner_q] = 1'b1;
          state_d            = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      winner_q    <= PORT_CPU;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      winner_q    <= winner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus.m0_gnt    = gnt_q[PORT_CPU];
  assign bus.m0_rvalid = rvalid_q[PORT_CPU];
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_gnt    = gnt_q[PORT_DMA];
  assign bus.m1_rvalid = rvalid_q[PORT_DMA];
  assign bus.m1_rdata  = rdata1_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random two-requester traffic with random resets, run on several latency and
// priority configurations, checked cycle by cycle against a transaction model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int N_CYC = 3000;
  localparam int N_CFG = 4;

  logic clk = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  function automatic int cfg_lat(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 1;
      default: return 7;
    endcase
  endfunction

  function automatic int cfg_fp(input int i);
    return (i >= 2) ? 1 : 0;
  endfunction

  // Memory contents are a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  for (genvar gi = 0; gi < N_CFG; gi++) begin : g_cfg
    localparam int LAT = cfg_lat(gi);
    localparam int FP  = cfg_fp(gi);

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
    logic   resetn;
    state_e dbg_state;
    bit     fin = 1'b0;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT), .FIXED_PRI(FP)) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .dbg_state (dbg_state)
    );

    // Model: per-cycle expectations derived from transaction timing rules.
    int          next_idle, rv_at, memv_at, rst_left;
    logic        last_g, rv_port, w;
    logic [1:0]  pend, p_we, e_gnt, e_rv;
    logic        e_we;
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata[2];
    logic [31:0] e_rdata[2];
    logic [31:0] e_addr, e_wdata, memv_addr;
    logic [31:0] exp_q[$];

    initial begin
      resetn = 1'b0; rst_left = 3;
      next_idle = 0; rv_at = -1; memv_at = -1; last_g = 1'b1; rv_port = 1'b0;
      pend = '0; p_we = '0; e_gnt = '0; e_rv = '0; e_we = 1'b0;
      e_addr = '0; e_wdata = '0; memv_addr = '0;
      for (int p = 0; p < 2; p++) begin
        p_addr[p] = '0; p_wdata[p] = '0; e_rdata[p] = '0;
      end
      bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
      bus.mem_rdata = '0;

      for (int c = 0; c < N_CYC; c++) begin
        @(negedge clk);
        // Compare this cycle's outputs.
        check($sformatf("cfg%0d.pulses", gi),
              {bus.m1_gnt, bus.m0_gnt, bus.m1_rvalid, bus.m0_rvalid, bus.mem_we},
              {e_gnt[1], e_gnt[0], e_rv[1], e_rv[0], e_we});
        check($sformatf("cfg%0d.mem_addr", gi), bus.mem_addr, e_addr);
        check($sformatf("cfg%0d.mem_wdata", gi), bus.mem_wdata, e_wdata);
        check($sformatf("cfg%0d.m0_rdata", gi), bus.m0_rdata, e_rdata[0]);
        check($sformatf("cfg%0d.m1_rdata", gi), bus.m1_rdata, e_rdata[1]);
        check($sformatf("cfg%0d.idle", gi), dbg_state == IDLE, c >= next_idle);

        // Requesters: drop after gnt, otherwise occasionally start a new access.
        for (int p = 0; p < 2; p++) begin
          if (e_gnt[p]) pend[p] = 1'b0;
          if (!pend[p] && $urandom_range(0, 2) == 0) begin
            pend[p]    = 1'b1;
            p_we[p]    = 1'($urandom_range(0, 1));
            p_addr[p]  = 32'($urandom_range(0, 255)) << 2;
            p_wdata[p] = $urandom();
          end
        end
        bus.m0_req = pend[0]; bus.m0_we = p_we[0]; bus.m0_addr = p_addr[0]; bus.m0_wdata = p_wdata[0];
        bus.m1_req = pend[1]; bus.m1_we = p_we[1]; bus.m1_addr = p_addr[1]; bus.m1_wdata = p_wdata[1];

        // Memory returns real data only on the cycle it is due; garbage otherwise.
        bus.mem_rdata = (c == memv_at) ? mem_word(memv_addr) : $urandom();

        if (rst_left == 0 && $urandom_range(0, 79) == 0) rst_left = $urandom_range(1, 2);

        e_gnt = '0; e_rv = '0; e_we = 1'b0;
        if (rst_left > 0) begin
          resetn = 1'b0;
          rst_left--;
          e_addr = '0; e_wdata = '0; e_rdata[0] = '0; e_rdata[1] = '0;
          last_g = 1'b1; next_idle = c + 1; rv_at = -1; memv_at = -1;
          exp_q.delete();
        end else begin
          resetn = 1'b1;
          if (c + 1 == rv_at && exp_q.size() > 0) begin
            e_rv[rv_port]    = 1'b1;
            e_rdata[rv_port] = exp_q.pop_front();
          end
          if (c >= next_idle && pend != 2'b00) begin
            if      (pend == 2'b01) w = 1'b0;
            else if (pend == 2'b10) w = 1'b1;
            else if (FP != 0)       w = 1'b0;
            else                    w = ~last_g;
            last_g   = w;
            e_gnt[w] = 1'b1;
            e_addr   = p_addr[w];
            e_wdata  = p_wdata[w];
            if (p_we[w]) begin
              e_we      = 1'b1;
              next_idle = c + 2;
            end else begin
              exp_q.push_back(mem_word(p_addr[w]));
              rv_port   = w;
              memv_at   = c + 1 + LAT;
              memv_addr = p_addr[w];
              rv_at     = c + 2 + LAT;
              next_idle = c + 3 + LAT;
            end
          end
        end
      end
      fin = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < N_CYC + 200; k++) begin
      if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) break;
      @(posedge clk);
    end
    check("all_cfgs_done",
          {g_cfg[3].fin, g_cfg[2].fin, g_cfg[1].fin, g_cfg[0].fin}, 4'hF);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
